// File: rtl/hls_srl_fifo_pkg.sv
// hls_srl_fifo_pkg
// Shared definitions for the shift-register FIFO:
//   - cnt_width(): width of the occupancy counter for a given index width
//   - flag level constants and the packed status-flag bundle
package hls_srl_fifo_pkg;

    // Flag levels, named so the reset values read as intent
    localparam logic FLAG_LOW  = 1'b0;
    localparam logic FLAG_HIGH = 1'b1;

    // Registered status flags
    typedef struct packed {
        logic empty_n;
        logic full_n;
        logic almost_full;
    } flags_t;

    // The occupancy counter needs one extra bit over the index so that
    // it can hold the value DEPTH when DEPTH == 2**ADDR_WIDTH.
    function automatic int unsigned cnt_width(input int unsigned addr_w);
        return addr_w + 32'd1;
    endfunction

endpackage

// File: rtl/hls_srl_fifo_shiftreg.sv
// hls_srl_fifo_shiftreg
// Storage for hls_srl_fifo: a plain shift register that maps onto SRL
// primitives. It has no reset; the FIFO's control logic alone decides
// which entries are valid.
// Ports:
//   clk  - clock
//   we   - shift enable: all entries move up one slot, din enters slot 0
//   addr - read index (0 = newest entry)
//   din  - data shifted in
//   dout - combinational read of slot addr
module hls_srl_fifo_shiftreg #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Shift chain: no reset so the tools can pack it into SRLs
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[0] <= din;
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_r[i] <= mem_r[i-1];
            end
        end
    end

    // Addressed read; indices beyond DEPTH only occur when the FIFO is empty
    always_comb begin
        if (int'(addr) < DEPTH) begin
            dout = mem_r[addr];
        end else begin
            dout = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/hls_srl_fifo.sv
// hls_srl_fifo
// First-word-fall-through FIFO built on a shift register. New words enter
// slot 0 and push older words up; the oldest word sits at slot count-1
// and is presented on if_dout without a register stage.
// Optional build macro: HLS_SRL_FIFO_ERR_EN adds the sticky if_err output.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   if_write_ce, if_write, if_din - write side (enable, request, data)
//   if_full_n, if_almost_full     - registered write-side status
//   if_read_ce, if_read           - read side (enable, request)
//   if_dout                       - oldest entry, don't-care when empty
//   if_empty_n                    - registered read-side status
//   if_count                      - current occupancy 0..DEPTH
//   if_err (HLS_SRL_FIFO_ERR_EN)  - sticky overflow/underflow attempt
module hls_srl_fifo
    import hls_srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4,
    parameter int AF_MARGIN  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count
`ifdef HLS_SRL_FIFO_ERR_EN
    ,
    output logic                  if_err
`endif
);

    localparam int unsigned      CNT_W      = cnt_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LEVEL_C = CNT_W'(DEPTH - AF_MARGIN);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE_C = ADDR_WIDTH'(1);
    // Only reachable with an illegal AF_MARGIN == DEPTH
    localparam logic AF_RESET_C = (DEPTH == AF_MARGIN) ? FLAG_HIGH : FLAG_LOW;

    logic                  wr_s;
    logic                  rd_s;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    flags_t                flags_r;
    flags_t                flags_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;

    // Accepted handshakes are qualified by the registered flags only
    assign wr_s = if_write & if_write_ce & flags_r.full_n;
    assign rd_s = if_read  & if_read_ce  & flags_r.empty_n;

    // Next occupancy and the flags it implies
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_s, rd_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
        flags_nxt_s.empty_n     = (count_nxt_s != {CNT_W{1'b0}});
        flags_nxt_s.full_n      = (count_nxt_s != DEPTH_C);
        flags_nxt_s.almost_full = (count_nxt_s >= AF_LEVEL_C);
    end

    // Control state; storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
            flags_r <= '{empty_n: FLAG_LOW, full_n: FLAG_HIGH, almost_full: AF_RESET_C};
        end else begin
            count_r <= count_nxt_s;
            flags_r <= flags_nxt_s;
        end
    end

    // Oldest word lives at count-1; wraps harmlessly when empty
    assign rd_addr_s = count_r[ADDR_WIDTH-1:0] - ADDR_ONE_C;

    hls_srl_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_shiftreg (
        .clk  (clk),
        .we   (wr_s),
        .addr (rd_addr_s),
        .din  (if_din),
        .dout (if_dout)
    );

    assign if_full_n      = flags_r.full_n;
    assign if_empty_n     = flags_r.empty_n;
    assign if_almost_full = flags_r.almost_full;
    assign if_count       = count_r;

`ifdef HLS_SRL_FIFO_ERR_EN
    logic err_r;
    logic err_set_s;

    // Any request the FIFO had to refuse
    assign err_set_s = (if_write & if_write_ce & ~flags_r.full_n) |
                       (if_read  & if_read_ce  & ~flags_r.empty_n);

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign if_err = err_r;
`endif

endmodule

// File: tb/tb_hls_srl_fifo.sv
module tb_hls_srl_fifo;

    localparam int DW  = 8;
    localparam int AW  = 2;
    localparam int DEP = 4;
    localparam int AFM = 1;

    logic          clk;
    logic          reset;
    logic          if_write_ce, if_write, if_read_ce, if_read;
    logic [DW-1:0] if_din;
    logic          if_full_n, if_almost_full, if_empty_n;
    logic [DW-1:0] if_dout;
    logic [AW:0]   if_count;
`ifdef HLS_SRL_FIFO_ERR_EN
    logic          if_err;
`endif

    hls_srl_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEP),
        .AF_MARGIN  (AFM)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_write_ce    (if_write_ce),
        .if_write       (if_write),
        .if_din         (if_din),
        .if_full_n      (if_full_n),
        .if_almost_full (if_almost_full),
        .if_read_ce     (if_read_ce),
        .if_read        (if_read),
        .if_dout        (if_dout),
        .if_empty_n     (if_empty_n),
        .if_count       (if_count)
`ifdef HLS_SRL_FIFO_ERR_EN
        ,
        .if_err         (if_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: an ordinary queue, oldest word at the front
    logic [DW-1:0] q[$];
    logic          err_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on the same edge the DUT samples
    always @(posedge clk) begin
        bit do_wr, do_rd;
        if (reset) begin
            q.delete();
            err_m <= 1'b0;
        end else begin
            do_wr = if_write && if_write_ce && (q.size() < DEP);
            do_rd = if_read && if_read_ce && (q.size() > 0);
            if ((if_write && if_write_ce && q.size() == DEP) ||
                (if_read && if_read_ce && q.size() == 0))
                err_m <= 1'b1;
            if (do_rd) void'(q.pop_front());
            if (do_wr) q.push_back(if_din);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_count",   32'(if_count),       32'(q.size()));
            chk("m_empty_n", 32'(if_empty_n),     32'(q.size() != 0));
            chk("m_full_n",  32'(if_full_n),      32'(q.size() != DEP));
            chk("m_afull",   32'(if_almost_full), 32'(q.size() >= DEP - AFM));
            if (q.size() > 0) chk("m_dout", 32'(if_dout), 32'(q[0]));
`ifdef HLS_SRL_FIFO_ERR_EN
            chk("m_err", 32'(if_err), 32'(err_m));
`endif
        end
    end

    // One clock: drive at negedge, outputs settle by the next negedge
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic wce = 1'b1, input logic rce = 1'b1);
        if_write = w; if_din = d; if_read = r;
        if_write_ce = wce; if_read_ce = rce;
        @(negedge clk);
        if_write = 1'b0; if_read = 1'b0;
    endtask

    logic [7:0] rd_exp [4];

    initial begin
        reset = 1'b1; if_write = 1'b0; if_read = 1'b0;
        if_write_ce = 1'b1; if_read_ce = 1'b1; if_din = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_count",   32'(if_count),       32'd0);
        chk("rst_empty_n", 32'(if_empty_n),     32'd0);
        chk("rst_full_n",  32'(if_full_n),      32'd1);
        chk("rst_afull",   32'(if_almost_full), 32'd0);

        // Three writes: almost full, oldest on the output
        step(1'b1, 8'h11, 1'b0);
        chk("w1_empty_n", 32'(if_empty_n), 32'd1);
        chk("w1_dout",    32'(if_dout),    32'h11);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk("w3_count",  32'(if_count),       32'd3);
        chk("w3_afull",  32'(if_almost_full), 32'd1);
        chk("w3_full_n", 32'(if_full_n),      32'd1);
        chk("w3_dout",   32'(if_dout),        32'h11);

        // Fill, then an overflow write that must be dropped
        step(1'b1, 8'h44, 1'b0);
        chk("w4_full_n", 32'(if_full_n), 32'd0);
        step(1'b1, 8'h55, 1'b0);
        chk("ovf_count", 32'(if_count), 32'd4);
`ifdef HLS_SRL_FIFO_ERR_EN
        chk("ovf_err", 32'(if_err), 32'd1);
`endif
        rd_exp[0] = 8'h11; rd_exp[1] = 8'h22; rd_exp[2] = 8'h33; rd_exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            chk("drain_dout", 32'(if_dout), 32'(rd_exp[i]));
            step(1'b0, 8'h00, 1'b1);
        end
        chk("drain_empty_n", 32'(if_empty_n), 32'd0);

        // Empty: write with a concurrent read; the read is ignored
        step(1'b1, 8'h5A, 1'b1);
        chk("fwft_empty_n", 32'(if_empty_n), 32'd1);
        chk("fwft_dout",    32'(if_dout),    32'h5A);
        chk("fwft_count",   32'(if_count),   32'd1);

        // count=2, simultaneous write and read
        step(1'b1, 8'h99, 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        chk("wr_rd_count",   32'(if_count),       32'd2);
        chk("wr_rd_dout",    32'(if_dout),        32'h99);
        chk("wr_rd_afull",   32'(if_almost_full), 32'd0);
        chk("wr_rd_empty_n", 32'(if_empty_n),     32'd1);

        // Reset mid-operation with a write pending
        step(1'b1, 8'hBB, 1'b0);
        chk("pre_rst_count", 32'(if_count), 32'd3);
        reset = 1'b1; if_write = 1'b1; if_din = 8'hCC;
        @(negedge clk);
        reset = 1'b0; if_write = 1'b0;
        chk("mid_rst_count",   32'(if_count),   32'd0);
        chk("mid_rst_empty_n", 32'(if_empty_n), 32'd0);
        step(1'b1, 8'h77, 1'b0);
        chk("post_rst_dout", 32'(if_dout), 32'h77);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_empty", 32'(if_empty_n), 32'd0);

        // Full with write+read: only the read is taken
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        step(1'b1, 8'hC4, 1'b0);
        step(1'b1, 8'hD5, 1'b1);
        chk("full_wr_rd_count", 32'(if_count), 32'd3);
        chk("full_wr_rd_dout",  32'(if_dout),  32'hC2);

        // Clock enables gate the requests
        step(1'b1, 8'hD0, 1'b0, 1'b0, 1'b1);
        chk("wce_off_count", 32'(if_count), 32'd3);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("rce_off_dout", 32'(if_dout), 32'hC2);

        // Drain plus an underflow read
        repeat (4) step(1'b0, 8'h00, 1'b1);
        chk("udf_count", 32'(if_count), 32'd0);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("end_rst_count", 32'(if_count), 32'd0);
`ifdef HLS_SRL_FIFO_ERR_EN
        chk("end_rst_err", 32'(if_err), 32'd0);
`endif
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
